// File: rtl/hilo_mult_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_mult_unit
// Description : Multi-cycle multiply / multiply-accumulate unit that owns the
//               HI/LO register pair. Sits beside the main ALU in EX. It is
//               driven by the 5-bit ALUOp code from ALU control, and has a
//               Start/Busy/Done handshake so the hazard unit can stall the
//               pipeline.
//               Supported ALUOp codes:
//                 26 multu, 30 madd, 29 msub, 31 mul,
//                 17 mthi, 19 mtlo, 28 mfhi, 27 mflo.
//               Optional macro MULT_SIGNED_EN: ALUOp 25 becomes signed mult.
//               Without the macro, ALUOp 25 is handled as an unsupported code.
// Parameters  : BITS_PER_CYCLE - multiplier bits retired per iteration
//               (1, 2 or 4). The iteration count is 32/BITS_PER_CYCLE.
// Ports       : Clk    - clock, rising edge
//               Reset  - synchronous, active-high reset
//               Start  - operation request (sampled only in IDLE)
//               ALUOp  - operation code
//               A, B   - operands (rs multiplicand / rt multiplier)
//               Result - registered GPR result (mul/mfhi/mflo)
//               HI, LO - HI/LO registers
//               Busy   - a multiply-class op is in flight
//               Done   - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_mult_unit #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [4:0]  ALUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Result,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        Done
);

  localparam int         N        = 32 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST_CNT = 5'(N - 1);

  localparam logic [4:0] OP_MTHI  = 5'd17;
  localparam logic [4:0] OP_MTLO  = 5'd19;
  localparam logic [4:0] OP_MULT  = 5'd25;
  localparam logic [4:0] OP_MULTU = 5'd26;
  localparam logic [4:0] OP_MFLO  = 5'd27;
  localparam logic [4:0] OP_MFHI  = 5'd28;
  localparam logic [4:0] OP_MSUB  = 5'd29;
  localparam logic [4:0] OP_MADD  = 5'd30;
  localparam logic [4:0] OP_MUL   = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MUL    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t      state_q,  state_d;
  logic [4:0]  cnt_q,    cnt_d;
  logic [4:0]  op_q,     op_d;
  logic        neg_q,    neg_d;
  logic [63:0] mcand_q,  mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] acc_q,    acc_d;
  logic [31:0] hi_q,     hi_d;
  logic [31:0] lo_q,     lo_d;
  logic [31:0] result_q, result_d;
  logic        busy_q,   busy_d;
  logic        done_q,   done_d;

  logic        w_mul_class;
  logic        w_signed_op;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [63:0] w_digit;
  logic [63:0] w_prod;

  // Decode of the incoming opcode (only meaningful in IDLE).
  always_comb begin
    w_mul_class = 1'b0;
    w_signed_op = 1'b0;
    case (ALUOp)
      OP_MULTU:                  w_mul_class = 1'b1;
      OP_MADD, OP_MSUB, OP_MUL: begin
        w_mul_class = 1'b1;
        w_signed_op = 1'b1;
      end
`ifdef MULT_SIGNED_EN
      OP_MULT: begin
        w_mul_class = 1'b1;
        w_signed_op = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Signed ops run on magnitudes. -0x80000000 wraps to 0x80000000, which is
  // exactly the correct unsigned magnitude 2^31.
  assign w_a_mag = (w_signed_op && A[31]) ? -A : A;
  assign w_b_mag = (w_signed_op && B[31]) ? -B : B;

  // Next multiplier digit, zero-extended so the partial product is 64 bits.
  assign w_digit = 64'(mplier_q[BITS_PER_CYCLE-1:0]);

  // Final signed product: negate the magnitude product when signs differ.
  assign w_prod  = neg_q ? -acc_q : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (w_mul_class) begin
            op_d     = ALUOp;
            neg_d    = w_signed_op & (A[31] ^ B[31]);
            mcand_d  = {32'd0, w_a_mag};
            mplier_d = w_b_mag;
            acc_d    = 64'd0;
            cnt_d    = 5'd0;
            busy_d   = 1'b1;
            state_d  = S_MUL;
          end else begin
            done_d = 1'b1;
            case (ALUOp)
              OP_MTHI: hi_d     = A;
              OP_MTLO: lo_d     = A;
              OP_MFHI: result_d = hi_q;
              OP_MFLO: result_d = lo_q;
              default: result_d = 32'd0;
            endcase
          end
        end
      end

      S_MUL: begin
        acc_d    = acc_q + (mcand_q * w_digit);
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
        case (op_q)
          OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + w_prod;
          OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - w_prod;
          OP_MUL:  result_d     = w_prod[31:0];
          default: {hi_d, lo_d} = w_prod;   // multu (and mult when enabled)
        endcase
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 5'd0;
      neg_q    <= 1'b0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      result_q <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Result = result_q;
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_mult_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_mult_unit
// Description : Self-checking bench for hilo_mult_unit. A behavioural model
//               (plain 64-bit arithmetic) tracks the expected HI/LO/Result/
//               Busy/Done, and one compare process checks every cycle.
//               Directed scenarios add literal expectations; a random phase
//               then mixes all opcodes, with stray Starts during Busy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_mult_unit;

  localparam int BPC = 1;
  localparam int N   = 32 / BPC;

  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic [4:0]  ALUOp;
  logic [31:0] A, B;
  logic [31:0] Result, HI, LO;
  logic        Busy, Done;

  hilo_mult_unit #(.BITS_PER_CYCLE(BPC)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ALUOp(ALUOp), .A(A), .B(B),
    .Result(Result), .HI(HI), .LO(LO), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;
  int   busy_cnt = 0;

  logic [31:0] e_hi, e_lo, e_res;
  logic        e_busy, e_done;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model-vs-DUT compare, every cycle, on the inactive edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      check32("HI",     HI,     e_hi);
      check32("LO",     LO,     e_lo);
      check32("Result", Result, e_res);
      check32("Busy",   {31'd0, Busy}, {31'd0, e_busy});
      check32("Done",   {31'd0, Done}, {31'd0, e_done});
    end
    if (Busy === 1'b1) busy_cnt++;
  end

  function automatic bit is_mul_class(input logic [4:0] op);
`ifdef MULT_SIGNED_EN
    if (op == 5'd25) return 1'b1;
`endif
    return (op == 5'd26) || (op == 5'd29) || (op == 5'd30) || (op == 5'd31);
  endfunction

  function automatic logic [63:0] model_prod(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (op == 5'd26) return {32'd0, a} * {32'd0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk); #1;
      e_done = 1'b0;
    end
  endtask

  // Issue one op. Returns 1 time unit after the completion edge, with Done
  // still expected high, so the next issue lands in the Done cycle.
  // inj >= 0 places a stray Start (ignored) before MUL edge inj+1.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int inj);
    logic [63:0] p;
    Start = 1'b1; ALUOp = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0; ALUOp = 5'($urandom); A = $urandom; B = $urandom;
    e_done = 1'b0;
    if (is_mul_class(op)) begin
      e_busy = 1'b1;
      p = model_prod(op, a, b);
      for (int k = 0; k < N; k++) begin
        if (k == inj) begin
          Start = 1'b1; ALUOp = 5'd17; A = $urandom;
        end
        @(posedge Clk); #1;
        Start = 1'b0;
        e_done = 1'b0;
      end
      @(posedge Clk); #1;
      e_busy = 1'b0;
      e_done = 1'b1;
      case (op)
        5'd30:   {e_hi, e_lo} = {e_hi, e_lo} + p;
        5'd29:   {e_hi, e_lo} = {e_hi, e_lo} - p;
        5'd31:   e_res = p[31:0];
        default: {e_hi, e_lo} = p;
      endcase
    end else begin
      e_done = 1'b1;
      case (op)
        5'd17:   e_hi  = a;
        5'd19:   e_lo  = a;
        5'd28:   e_res = e_hi;
        5'd27:   e_res = e_lo;
        default: e_res = 32'd0;
      endcase
    end
  endtask

  logic [4:0] op_tab [11] = '{5'd26, 5'd30, 5'd29, 5'd31, 5'd17, 5'd19,
                              5'd28, 5'd27, 5'd25, 5'd0, 5'd5};

  initial begin
    logic [31:0] ra, rb;
    int          inj;
    Reset = 1'b1; Start = 1'b0; ALUOp = 5'd0; A = 32'd0; B = 32'd0;
    e_hi = 32'd0; e_lo = 32'd0; e_res = 32'd0; e_busy = 1'b0; e_done = 1'b0;
    @(posedge Clk); #1;
    chk_en = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    idle(1);

    // multu all-ones: Busy exactly 33 cycles, then HI/LO and Done pulse.
    busy_cnt = 0;
    issue(5'd26, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check32("multu_HI", HI, 32'hFFFF_FFFE);
    check32("multu_LO", LO, 32'h0000_0001);
    check32("multu_Done", {31'd0, Done}, 32'd1);
    check32("multu_busy_cycles", busy_cnt, 32'd33);
    idle(1);

    // MADD: {HI,LO} = 5, then += -2*3.
    issue(5'd19, 32'd5, 32'd0, -1);
    issue(5'd17, 32'd0, 32'd0, -1);
    issue(5'd30, 32'hFFFF_FFFE, 32'd3, -1);
    check32("madd_HI", HI, 32'hFFFF_FFFF);
    check32("madd_LO", LO, 32'hFFFF_FFFF);

    // MSUB from zero with the most-negative operands.
    issue(5'd17, 32'd0, 32'd0, -1);
    issue(5'd19, 32'd0, 32'd0, -1);
    issue(5'd29, 32'h8000_0000, 32'h8000_0000, -1);
    check32("msub_HI", HI, 32'hC000_0000);
    check32("msub_LO", LO, 32'h0000_0000);

    // mul leaves HI/LO alone; mflo then reads LO.
    issue(5'd19, 32'h1234_5678, 32'd0, -1);
    issue(5'd31, 32'hFFFF_FFF9, 32'd6, -1);
    check32("mul_Result", Result, 32'hFFFF_FFD6);
    check32("mul_HI", HI, 32'hC000_0000);
    check32("mul_LO", LO, 32'h1234_5678);
    issue(5'd27, 32'd0, 32'd0, -1);
    check32("mflo_Result", Result, 32'h1234_5678);
    idle(1);

    // multu with a stray mthi at E0+5, then Reset at E0+10.
    Start = 1'b1; ALUOp = 5'd26; A = 32'hDEAD_BEEF; B = 32'h0000_1234;
    @(posedge Clk); #1;
    Start = 1'b0; e_busy = 1'b1; e_done = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 5) begin
        Start = 1'b1; ALUOp = 5'd17; A = 32'hAAAA_5555;
      end
      @(posedge Clk); #1;
      Start = 1'b0;
    end
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    e_hi = 32'd0; e_lo = 32'd0; e_res = 32'd0; e_busy = 1'b0; e_done = 1'b0;
    check32("abort_Busy", {31'd0, Busy}, 32'd0);
    idle(N + 4);
    check32("abort_HI", HI, 32'd0);

    // mfhi in the Done cycle sees the freshly written HI.
    issue(5'd26, 32'h0001_0000, 32'h0001_0000, -1);
    issue(5'd28, 32'd0, 32'd0, -1);
    check32("mfhi_in_done_Result", Result, 32'h0000_0001);

    // Unsupported opcode clears Result and pulses Done.
    issue(5'd0, 32'hFFFF_FFFF, 32'd1, -1);
    check32("unsup_Result", Result, 32'd0);
    check32("unsup_Done", {31'd0, Done}, 32'd1);
    idle(1);

    // Random mix.
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      inj = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, N - 1));
      issue(op_tab[$urandom_range(0, 10)], ra, rb, inj);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
    end

    idle(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
- Multi-cycle multiply / multiply-accumulate unit that owns the HI/LO register pair.
- It is the execute-side consumer of the 5-bit ALUOp code produced by ALU control.
- Sits beside the main ALU in EX. It accepts ALUOp codes 26 (multu), 30 (MADD), 29 (MSUB), 31 (mul), 17 (mthi), 19 (mtlo), 28 (mfhi) and 27 (mflo).
- Provides a Start/Busy/Done handshake so the hazard unit can stall the pipeline.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits retired per iteration; legal values 1, 2, 4. Iteration count N = 32/BITS_PER_CYCLE.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  operation request; sampled only in IDLE.
- ALUOp  input  5  operation code from ALU control.
- A  input  32  operand rs (multiplicand; source for mthi/mtlo).
- B  input  32  operand rt (multiplier).
- Result  output  32  registered GPR result for mul/mfhi/mflo.
- HI  output  32  HI register.
- LO  output  32  LO register.
- Busy  output  1  high while a multiply-class op is in progress.
- Done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, internal accumulator/counter 0, state IDLE. Reset overrides Start and any in-flight op.
- States:
  - IDLE: Start accepted only here.
  - MUL: N iterations.
  - FINISH: one cycle.
- Multiply-class ops (26, 30, 29, 31), Start=1 at edge E0:
  - Capture A, B; counter cleared; go to MUL; Busy=1 after E0.
  - Signed ops (30, 29, 31): operate on magnitudes. Product sign = A[31]^B[31], applied in FINISH by two's-complement negation of the 64-bit magnitude product.
  - Unsigned op (26): operands used as-is.
  - MUL: each edge adds the shifted multiplicand times the next BITS_PER_CYCLE multiplier bits into a 64-bit partial product; counter increments. At counter = N-1, go to FINISH.
  - FINISH edge (E0+N+1), registered outputs:
    - multu: {HI,LO} <= P.
    - MADD: {HI,LO} <= {HI,LO} + P, mod 2^64.
    - MSUB: {HI,LO} <= {HI,LO} - P, mod 2^64.
    - mul: Result <= P[31:0]; HI/LO unchanged.
    - In all cases Done <= 1, Busy <= 0, state goes to IDLE.
  - Latency: Done and updated values visible after edge E0+N+1 (33 edges for BITS_PER_CYCLE=1, 9 for 4). Done high for exactly one cycle.
- Single-cycle ops, Start=1 in IDLE at E0 (Busy never asserts; Done pulses after E0):
  - mthi: HI <= A.
  - mtlo: LO <= A.
  - mfhi: Result <= HI (value before E0).
  - mflo: Result <= LO.
- Unsupported ALUOp with Start=1: no state change, Result <= 0, Done pulses once.
- Start while Busy (MUL or FINISH): ignored, no queuing; the stall is the caller's responsibility.
- Start in the cycle Done is high: accepted normally (state is IDLE). mfhi/mflo then read the updated HI/LO.
- Result holds its last value until the next mul/mfhi/mflo/unsupported op.
- Operands captured at E0; A/B changes during MUL have no effect.
- Reset mid-MUL: operation abandoned, no Done pulse, HI=LO=0.

Optional Feature:
- MULT_SIGNED_EN defined: ALUOp 25 = signed mult; {HI,LO} <= signed A*B, same latency and handshake as multu.
- Not defined: ALUOp 25 is treated as unsupported (Result <= 0, Done pulse, HI/LO unchanged).

Test Plan:
- multu: A=0xFFFFFFFF, B=0xFFFFFFFF, BITS_PER_CYCLE=1 -> Busy high 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001; Done high one cycle at E0+33.
- MADD after mtlo A=5 and mthi A=0: A=0xFFFFFFFE (-2), B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF.
- MSUB from HI=LO=0: A=0x80000000, B=0x80000000 -> HI=0xC0000000, LO=0x00000000.
- mul A=0xFFFFFFF9 (-7), B=6 -> Result=0xFFFFFFD6; HI/LO unchanged; then mflo -> Result equals prior LO one edge later, Busy stays 0.
- multu started, extra Start with mthi at E0+5 -> mthi ignored. Reset at E0+10 -> Busy=0, Done never pulses, HI=LO=Result=0.
- mfhi issued in the cycle Done is high after multu 0x00010000*0x00010000 -> Result=0x00000001.
